// File: rtl/config_pkg.sv
// Shared types and constants for the operand fetch sequencer.
package config_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 16;
    localparam int OPCODE_W = 4;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [2*DATA_W-1:0] w_data_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [OPCODE_W-1:0] code_t;

    typedef struct packed {
        code_t opcode;
        addr_t addr_a;
        addr_t addr_b;
        addr_t addr_c;
    } uinstr_t;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/operand_collect.sv
// Collects the four in-order read responses into staging registers and
// publishes A, B and the double-width C together when the last word lands.
module operand_collect
    import config_pkg::*;
(
    input  logic    clk,
    input  logic    arst_ni,
    input  logic    clr,
    input  logic    rsp_vld,
    input  data_t   rsp_data,
    output logic    done,
    output data_t   operand_a,
    output data_t   operand_b,
    output w_data_t operand_c
);

    logic [1:0] rsp_cnt;
    data_t      a_stage;
    data_t      b_stage;
    data_t      c_hi_stage;

    // The fourth response (C low word) completes the operation.
    assign done = rsp_vld && (rsp_cnt == 2'd3);

    // Response counter: selects which operand slot the next word fills.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            rsp_cnt <= '0;
        end else if (clr) begin
            rsp_cnt <= '0;
        end else if (rsp_vld) begin
            rsp_cnt <= rsp_cnt + 2'd1;
        end
    end

    // Stage the first three words; the last word goes straight to the output.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            a_stage    <= '0;
            b_stage    <= '0;
            c_hi_stage <= '0;
        end else if (rsp_vld && !clr) begin
            case (rsp_cnt)
                2'd0:    a_stage    <= rsp_data;
                2'd1:    b_stage    <= rsp_data;
                2'd2:    c_hi_stage <= rsp_data;
                default: ;
            endcase
        end
    end

    // Operand outputs only move on completion so they stay frozen otherwise.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            operand_a <= '0;
            operand_b <= '0;
            operand_c <= '0;
        end else if (done) begin
            operand_a <= a_stage;
            operand_b <= b_stage;
            operand_c <= {c_hi_stage, rsp_data};
        end
    end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: accepts a micro-instruction, issues four reads
// (A, B, C high, C low) on a request/grant port, gathers the in-order
// responses and presents the assembled operation to the execution stage.
module operand_fetch_ctrl
    import config_pkg::*;
(
    input  logic    clk,
    input  logic    arst_ni,
    input  uinstr_t uinstr_i,
    input  logic    uinstr_valid_i,
    output logic    uinstr_ready_o,
    output logic    rd_req_o,
    output addr_t   rd_addr_o,
    input  logic    rd_gnt_i,
    input  logic    rd_data_valid_i,
    input  data_t   rd_data_i,
    output data_t   operand_a_o,
    output data_t   operand_b_o,
    output w_data_t operand_c_o,
    output code_t   op_code_o,
    output uinstr_t uinstr_o,
    output logic    op_valid_o,
    input  logic    op_ready_i,
    output logic    err_o
);

    state_t     state;
    state_t     state_nxt;
    uinstr_t    uinstr_q;
    logic [1:0] iss_cnt;
    logic       err_q;
    logic       accept;
    logic       grant;
    logic       rsp_vld;
    logic       done;

    assign accept  = (state == ST_IDLE) && uinstr_valid_i;
    assign grant   = rd_req_o && rd_gnt_i;
    // Responses are only meaningful while a fetch is outstanding.
    assign rsp_vld = rd_data_valid_i && ((state == ST_ISSUE) || (state == ST_WAIT));

    assign uinstr_ready_o = (state == ST_IDLE);
    assign rd_req_o       = (state == ST_ISSUE);
    assign op_valid_o     = (state == ST_HOLD);
    assign op_code_o      = uinstr_q.opcode;
    assign uinstr_o       = uinstr_q;
    assign err_o          = err_q;

    // Next-state logic for the fetch sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (uinstr_valid_i) state_nxt = ST_ISSUE;
            ST_ISSUE: if (grant && (iss_cnt == 2'd3)) state_nxt = ST_WAIT;
            ST_WAIT:  if (done) state_nxt = ST_HOLD;
            ST_HOLD:  if (op_ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Read address follows the issue count; C low wraps within the address space.
    always_comb begin
        rd_addr_o = '0;
        if (rd_req_o) begin
            case (iss_cnt)
                2'd0:    rd_addr_o = uinstr_q.addr_a;
                2'd1:    rd_addr_o = uinstr_q.addr_b;
                2'd2:    rd_addr_o = uinstr_q.addr_c;
                default: rd_addr_o = uinstr_q.addr_c + addr_t'(1);
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the micro-instruction and restart the issue count on acceptance.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            uinstr_q <= '0;
            iss_cnt  <= '0;
        end else if (accept) begin
            uinstr_q <= uinstr_i;
            iss_cnt  <= '0;
        end else if (grant) begin
            iss_cnt  <= iss_cnt + 2'd1;
        end
    end

    // Sticky flag for responses that arrive with no fetch outstanding.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q <= 1'b0;
        end else if (rd_data_valid_i && ((state == ST_IDLE) || (state == ST_HOLD))) begin
            err_q <= 1'b1;
        end
    end

    operand_collect u_collect (
        .clk       (clk),
        .arst_ni   (arst_ni),
        .clr       (accept),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rd_data_i),
        .done      (done),
        .operand_a (operand_a_o),
        .operand_b (operand_b_o),
        .operand_c (operand_c_o)
    );

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: directed fetches against a memory responder,
// a queue-based reference model checked every cycle, and literal expectations.
module tb_operand_fetch_ctrl;
    import config_pkg::*;

    logic    clk = 1'b0;
    logic    arst_ni = 1'b1;
    uinstr_t uinstr_i = '0;
    logic    uinstr_valid_i = 1'b0;
    logic    uinstr_ready_o;
    logic    rd_req_o;
    addr_t   rd_addr_o;
    logic    rd_gnt_i = 1'b0;
    logic    rd_data_valid_i = 1'b0;
    data_t   rd_data_i = '0;
    data_t   operand_a_o;
    data_t   operand_b_o;
    w_data_t operand_c_o;
    code_t   op_code_o;
    uinstr_t uinstr_o;
    logic    op_valid_o;
    logic    op_ready_i = 1'b0;
    logic    err_o;

    operand_fetch_ctrl dut (
        .clk             (clk),
        .arst_ni         (arst_ni),
        .uinstr_i        (uinstr_i),
        .uinstr_valid_i  (uinstr_valid_i),
        .uinstr_ready_o  (uinstr_ready_o),
        .rd_req_o        (rd_req_o),
        .rd_addr_o       (rd_addr_o),
        .rd_gnt_i        (rd_gnt_i),
        .rd_data_valid_i (rd_data_valid_i),
        .rd_data_i       (rd_data_i),
        .operand_a_o     (operand_a_o),
        .operand_b_o     (operand_b_o),
        .operand_c_o     (operand_c_o),
        .op_code_o       (op_code_o),
        .uinstr_o        (uinstr_o),
        .op_valid_o      (op_valid_o),
        .op_ready_i      (op_ready_i),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic data_t mem_word(input addr_t a);
        case (a)
            16'h0010: return 32'h0000_0011;
            16'h0020: return 32'h0000_0022;
            16'h0030: return 32'h0000_0033;
            16'h0031: return 32'h0000_0044;
            default:  return {16'hA5A5, a};
        endcase
    endfunction

    // ---------------- reference model ----------------
    bit      m_idle;
    bit      m_hold;
    bit      m_err;
    uinstr_t m_u;
    addr_t   m_reqs[$];
    data_t   m_words[$];
    data_t   m_a;
    data_t   m_b;
    w_data_t m_c;

    task automatic model_reset();
        m_idle = 1'b1;
        m_hold = 1'b0;
        m_err  = 1'b0;
        m_u    = '0;
        m_reqs.delete();
        m_words.delete();
        m_a = '0;
        m_b = '0;
        m_c = '0;
    endtask

    task automatic model_step();
        if (m_idle) begin
            if (rd_data_valid_i) m_err = 1'b1;
            if (uinstr_valid_i) begin
                m_u = uinstr_i;
                m_reqs.delete();
                m_words.delete();
                m_reqs.push_back(uinstr_i.addr_a);
                m_reqs.push_back(uinstr_i.addr_b);
                m_reqs.push_back(uinstr_i.addr_c);
                m_reqs.push_back(addr_t'(uinstr_i.addr_c + 16'd1));
                m_idle = 1'b0;
            end
        end else if (m_hold) begin
            if (rd_data_valid_i) m_err = 1'b1;
            if (op_ready_i) begin
                m_hold = 1'b0;
                m_idle = 1'b1;
            end
        end else begin
            if (m_reqs.size() > 0 && rd_gnt_i) void'(m_reqs.pop_front());
            if (rd_data_valid_i) begin
                m_words.push_back(rd_data_i);
                if (m_words.size() == 4) begin
                    m_a    = m_words[0];
                    m_b    = m_words[1];
                    m_c    = {m_words[2], m_words[3]};
                    m_hold = 1'b1;
                end
            end
        end
    endtask

    task automatic model_compare();
        bit    e_req;
        addr_t e_addr;
        e_req  = !m_idle && !m_hold && (m_reqs.size() > 0);
        e_addr = '0;
        if (e_req) e_addr = m_reqs[0];
        chk("uinstr_ready", 64'(uinstr_ready_o), 64'(m_idle));
        chk("op_valid", 64'(op_valid_o), 64'(m_hold));
        chk("rd_req", 64'(rd_req_o), 64'(e_req));
        chk("rd_addr", 64'(rd_addr_o), 64'(e_addr));
        chk("operand_a", 64'(operand_a_o), 64'(m_a));
        chk("operand_b", 64'(operand_b_o), 64'(m_b));
        chk("operand_c", operand_c_o, m_c);
        chk("op_code", 64'(op_code_o), 64'(m_u.opcode));
        chk("uinstr_o", 64'(uinstr_o), 64'(m_u));
        chk("err", 64'(err_o), 64'(m_err));
    endtask

    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) model_reset();
        else model_step();
        #1;
        model_compare();
    end

    // ---------------- stimulus / memory responder ----------------
    data_t pend[$];
    addr_t addr_log[$];
    addr_t stall_addr = '0;
    int    stall_left = 0;
    int    hold_left  = 0;
    bit    offer = 1'b0;
    bit    spur  = 1'b0;
    int    cyc   = 0;
    int    hs_cyc = -1;
    int    v_cyc  = -1;
    int    v_count = 0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend.size() > 0) begin
            rd_data_valid_i = 1'b1;
            rd_data_i       = pend.pop_front();
        end else if (spur) begin
            rd_data_valid_i = 1'b1;
            rd_data_i       = 32'hDEAD_BEEF;
            spur            = 1'b0;
        end else begin
            rd_data_valid_i = 1'b0;
            rd_data_i       = '0;
        end
        rd_gnt_i = 1'b1;
        if (rd_req_o && stall_left > 0 && rd_addr_o == stall_addr) begin
            rd_gnt_i = 1'b0;
            stall_left--;
        end
        if (rd_req_o && rd_gnt_i) begin
            pend.push_back(mem_word(rd_addr_o));
            addr_log.push_back(rd_addr_o);
        end
        uinstr_valid_i = offer;
        if (offer && uinstr_ready_o) begin
            hs_cyc = cyc;
            offer  = 1'b0;
        end
        op_ready_i = 1'b0;
        if (op_valid_o) begin
            if (v_cyc < 0) v_cyc = cyc;
            v_count++;
            if (hold_left > 0) hold_left--;
            else op_ready_i = 1'b1;
        end
    endtask

    task automatic run_op(input uinstr_t u, input int hold);
        bit finished;
        uinstr_i  = u;
        offer     = 1'b1;
        hold_left = hold;
        addr_log.delete();
        hs_cyc  = -1;
        v_cyc   = -1;
        v_count = 0;
        finished = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            step();
            if (v_count > 0 && !op_valid_o) finished = 1'b1;
        end
        chk("op_completed_in_bound", 64'(finished), 64'd1);
        // One bubble after op_ready: ready to accept again the next cycle.
        chk("ready_after_hold", 64'(uinstr_ready_o), 64'd1);
    endtask

    task automatic chk_addrs(input string name, input addr_t a0, input addr_t a1,
                             input addr_t a2, input addr_t a3);
        chk({name, "_n_req"}, 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            chk({name, "_addr0"}, 64'(addr_log[0]), 64'(a0));
            chk({name, "_addr1"}, 64'(addr_log[1]), 64'(a1));
            chk({name, "_addr2"}, 64'(addr_log[2]), 64'(a2));
            chk({name, "_addr3"}, 64'(addr_log[3]), 64'(a3));
        end
    endtask

    initial begin
        bit reached;
        #1 arst_ni = 1'b0;
        #1;
        chk("rst_uinstr_ready", 64'(uinstr_ready_o), 64'd1);
        chk("rst_rd_req", 64'(rd_req_o), 64'd0);
        chk("rst_op_valid", 64'(op_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_operand_c", operand_c_o, 64'd0);
        @(negedge clk);
        arst_ni = 1'b1;
        step();

        // Basic fetch
        run_op('{opcode: 4'd3, addr_a: 16'h0010, addr_b: 16'h0020, addr_c: 16'h0030}, 0);
        chk_addrs("basic", 16'h0010, 16'h0020, 16'h0030, 16'h0031);
        chk("basic_latency", 64'(v_cyc - hs_cyc), 64'd6);
        chk("basic_a", 64'(operand_a_o), 64'h11);
        chk("basic_b", 64'(operand_b_o), 64'h22);
        chk("basic_c", operand_c_o, 64'h0000_0033_0000_0044);
        chk("basic_op", 64'(op_code_o), 64'd3);

        // Grant stall on the B request
        stall_addr = 16'h0020;
        stall_left = 3;
        run_op('{opcode: 4'd7, addr_a: 16'h0100, addr_b: 16'h0020, addr_c: 16'h0200}, 0);
        chk_addrs("stall", 16'h0100, 16'h0020, 16'h0200, 16'h0201);
        chk("stall_used", 64'(stall_left), 64'd0);
        chk("stall_latency", 64'(v_cyc - hs_cyc), 64'd9);
        chk("stall_a", 64'(operand_a_o), 64'hA5A5_0100);
        chk("stall_b", 64'(operand_b_o), 64'h22);
        chk("stall_c", operand_c_o, 64'hA5A5_0200_A5A5_0201);

        // Backpressure for 5 cycles
        run_op('{opcode: 4'd9, addr_a: 16'h0001, addr_b: 16'h0002, addr_c: 16'h0003}, 5);
        chk("bp_valid_cycles", 64'(v_count), 64'd6);
        chk("bp_a", 64'(operand_a_o), 64'hA5A5_0001);
        chk("bp_c", operand_c_o, 64'hA5A5_0003_A5A5_0004);
        chk("bp_op", 64'(op_code_o), 64'd9);

        // Address wrap on C low
        run_op('{opcode: 4'hF, addr_a: 16'h0005, addr_b: 16'h0006, addr_c: 16'hFFFF}, 0);
        chk_addrs("wrap", 16'h0005, 16'h0006, 16'hFFFF, 16'h0000);
        chk("wrap_c", operand_c_o, 64'hA5A5_FFFF_A5A5_0000);

        // Spurious response while idle
        spur = 1'b1;
        step();
        step();
        chk("spur_err", 64'(err_o), 64'd1);
        chk("spur_idle", 64'(uinstr_ready_o), 64'd1);
        chk("spur_no_valid", 64'(op_valid_o), 64'd0);
        run_op('{opcode: 4'd2, addr_a: 16'h0030, addr_b: 16'h0031, addr_c: 16'h0010}, 0);
        chk("spur_then_a", 64'(operand_a_o), 64'h33);
        chk("spur_then_b", 64'(operand_b_o), 64'h44);
        chk("spur_then_c", operand_c_o, 64'h0000_0011_A5A5_0011);
        chk("spur_err_sticky", 64'(err_o), 64'd1);

        // Reset after the second grant
        uinstr_i = '{opcode: 4'd4, addr_a: 16'h0050, addr_b: 16'h0060, addr_c: 16'h0070};
        offer = 1'b1;
        addr_log.delete();
        for (int i = 0; i < 100 && addr_log.size() < 2; i++) step();
        reached = (addr_log.size() == 2);
        chk("rstmid_two_grants", 64'(reached), 64'd1);
        @(posedge clk);
        #2 arst_ni = 1'b0;
        offer = 1'b0;
        hold_left = 0;
        #1;
        chk("rstmid_ready", 64'(uinstr_ready_o), 64'd1);
        chk("rstmid_req", 64'(rd_req_o), 64'd0);
        chk("rstmid_addr", 64'(rd_addr_o), 64'd0);
        chk("rstmid_valid", 64'(op_valid_o), 64'd0);
        chk("rstmid_err", 64'(err_o), 64'd0);
        chk("rstmid_a", 64'(operand_a_o), 64'd0);
        chk("rstmid_uinstr", 64'(uinstr_o), 64'd0);
        step();
        #1 arst_ni = 1'b1;
        step();
        chk("late_rsp_err", 64'(err_o), 64'd1);
        chk("late_rsp_a", 64'(operand_a_o), 64'd0);
        run_op('{opcode: 4'd1, addr_a: 16'h0010, addr_b: 16'h0020, addr_c: 16'h0030}, 0);
        chk_addrs("post_rst", 16'h0010, 16'h0020, 16'h0030, 16'h0031);
        chk("post_rst_a", 64'(operand_a_o), 64'h11);
        chk("post_rst_c", operand_c_o, 64'h0000_0033_0000_0044);
        chk("post_rst_op", 64'(op_code_o), 64'd1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
